rr_mux_arbiter: RTL and testbench

- Shares one W-bit output channel between N requesters.
- Uses a round-robin arbiter that steers a registered N:1 multiplexer.
- Each requester presents valid/data; the arbiter grants one requester, captures its data into a one-entry output register, and holds it until the consumer accepts it.
- Sits between several producer blocks and a single shared downstream consumer.

---
 rtl/rr_mux_arbiter.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Shares one W-bit output channel between N requesters. A round-robin
//   arbiter picks one valid requester while the output register is empty,
//   captures its word into a one-entry output register and holds it until
//   the consumer accepts it. One word every two cycles at best.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [N]    requester i has a word
//   req_data   [N*W]  requester i word on bits [i*W +: W]
//   req_ready  [N]    one-hot or zero; requester's word taken this cycle
//   out_valid         output register holds a word
//   out_data   [W]    held word
//   out_ready         consumer accepts when out_valid && out_ready
//   out_src    [log2N] index of the requester whose word is held
//   grant      [N]    one-hot(out_src) while out_valid, zero otherwise
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_src,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [W-1:0]  win_data;
  logic [W-1:0]  data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_split
    assign data_arr[g] = req_data[g*W +: W];
  end

  // Scan ptr, ptr+1, ... wrapping at N-1. The sum is one bit wider than the
  // index so ptr+k never overflows before the wrap, and a single subtract
  // of N keeps every candidate below N even when N is not a power of two.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    sum       = '0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_data  = data_arr[cand];
      end
    end
  end

  // Ready only while the output register is empty; no out_ready bypass.
  assign req_ready = (state == IDLE && win_found) ? (N'(1) << win_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      grant     <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            out_data  <= win_data;
            out_src   <= win_idx;
            grant     <= N'(1) << win_idx;
            out_valid <= 1'b1;
            state     <= HOLD;
            // Pointer moves only on a real grant, to the slot after the winner.
            ptr       <= (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            grant     <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: an N=4 instance checked every cycle against a
// transaction-level round-robin model, directed scenarios with literal
// expectations, and an N=3 instance for the non-power-of-two wrap.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  out_src;
  logic [3:0]  grant;

  logic [2:0]  rv3;
  logic [23:0] rd3;
  logic [2:0]  rr3;
  logic        ov3;
  logic [7:0]  od3;
  logic        ordy3;
  logic [1:0]  os3;
  logic [2:0]  g3;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_src(out_src), .grant(grant)
  );

  rr_mux_arbiter #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_data(rd3),
    .req_ready(rr3), .out_valid(ov3), .out_data(od3),
    .out_ready(ordy3), .out_src(os3), .grant(g3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model (N=4) ----------------
  function automatic int rr_pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (((v >> i) & 4'd1) == 4'd1) return i;
    end
    return -1;
  endfunction

  bit         m_busy = 1'b0;
  int         m_ptr  = 0;
  int         m_src  = 0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      m_src  <= 0;
    end else if (!m_busy) begin
      if (rr_pick(m_ptr, req_valid) >= 0) begin
        m_busy <= 1'b1;
        m_src  <= rr_pick(m_ptr, req_valid);
        m_data <= 8'(req_data >> (8 * rr_pick(m_ptr, req_valid)));
        m_ptr  <= (rr_pick(m_ptr, req_valid) + 1) % 4;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int pk;
    int er;
    pk = rr_pick(m_ptr, req_valid);
    er = (!m_busy && pk >= 0) ? (1 << pk) : 0;
    chk("m_req_ready", int'(req_ready), er);
    chk("m_out_valid", int'(out_valid), int'(m_busy));
    chk("m_grant", int'(grant), m_busy ? (1 << m_src) : 0);
    if (m_busy) begin
      chk("m_out_src", int'(out_src), m_src);
      chk("m_out_data", int'(out_data), int'(m_data));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic expect_word(input int src, input int d, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 12);
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_src"},   int'(out_src), src);
    chk({nm, "_data"},  int'(out_data), d);
    chk({nm, "_grant"}, int'(grant), 1 << src);
  endtask

  initial begin
    int n;
    rst = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    rv3 = '0; rd3 = '0; ordy3 = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: asynchronous reset while holding 0xA5
    req_valid = 4'b0001; req_data = 32'h000000A5;
    expect_word(0, 8'hA5, "t1_word", n);
    #3 rst = 1'b1;
    #1;
    chk("t1_rst_valid", int'(out_valid), 0);
    chk("t1_rst_grant", int'(grant), 0);
    chk("t1_rst_data",  int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 4'b0110; req_data = 32'h44332211;
    expect_word(1, 8'h22, "t1_first", n);
    @(posedge clk); #1;
    out_ready = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);

    // 2: round-robin order with all requesting
    do_reset();
    req_valid = 4'b1111; req_data = 32'h33221100; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_word(i % 4, 8'h11 * (i % 4), "t2_rr", n);
      if (i > 0) chk("t2_gap", n, 2);
    end
    @(posedge clk); #1 req_valid = '0;

    // 3: backpressure on requester 2
    do_reset();
    req_valid = 4'b0100; req_data = 32'h005C0000; out_ready = 1'b0;
    expect_word(2, 8'h5C, "t3_word", n);
    @(posedge clk); #1 req_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_data",  int'(out_data), 8'h5C);
      chk("t3_hold_grant", int'(grant), 4'b0100);
      chk("t3_hold_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("t3_nobypass_valid", int'(out_valid), 1);
    chk("t3_nobypass_ready", int'(req_ready), 0);
    @(negedge clk);
    chk("t3_drained", int'(out_valid), 0);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);

    // 4: pointer skips idle slots
    do_reset();
    req_valid = 4'b0001; req_data = 32'h33221100; out_ready = 1'b1;
    expect_word(0, 8'h00, "t4_first", n);
    @(posedge clk); #1 req_valid = 4'b1001;
    expect_word(3, 8'h33, "t4_skip", n);
    expect_word(0, 8'h00, "t4_wrap", n);
    @(posedge clk); #1 req_valid = '0;

    // 5: withdrawn request and idle pointer stability
    do_reset();
    req_valid = 4'b0001; req_data = 32'h33221100; out_ready = 1'b0;
    expect_word(0, 8'h00, "t5_word", n);
    @(posedge clk); #1 req_valid = 4'b0011;
    @(posedge clk); #1 req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = 4'b0000;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_idle_ready", int'(req_ready), 0);
      chk("t5_idle_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1 req_valid = 4'b1111;
    expect_word(1, 8'h11, "t5_ptr_kept", n);
    @(posedge clk); #1 req_valid = '0;
    repeat (2) @(posedge clk);

    // 6: N=3 wrap
    #1;
    rv3 = 3'b111; rd3 = 24'h221100; ordy3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ov3 && n < 12);
      chk("t6_valid", int'(ov3), 1);
      chk("t6_src",   int'(os3), i % 3);
      chk("t6_range", (os3 < 2'd3) ? 1 : 0, 1);
      chk("t6_data",  int'(od3), 8'h11 * (i % 3));
      chk("t6_grant", int'(g3), 1 << (i % 3));
    end
    @(posedge clk); #1 rv3 = '0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
